uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
- Parametrised successor to the fixed 8N1 single-byte UART used by the system and its testbench UART partner.
- Configurable data bits, parity and stop bits, plus TX and RX FIFOs of configurable depth.
- Sticky error flags so the LM32 or a bench can run back-to-back traffic without per-byte polling.
- Sits between a Wishbone UART register wrapper (or a bench driver) and the uart_rxd/uart_txd pins.

Parameters:
- freq_hz, 100000000, system clock frequency in Hz.
- baud, 115200, line rate. 16x tick divisor = (freq_hz + 8*baud) / (16*baud), minimum 1.
- data_bits, 8, payload bits per frame; legal 5..8.
- parity, 0, 0 = none, 1 = odd, 2 = even.
- stop_bits, 1, legal 1 or 2.
- fifo_depth, 16, entries in each of the TX and RX FIFOs; power of two, 2..256.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- uart_rxd  in  1  serial input, asynchronous to clk.
- uart_txd  out  1  serial output, idle high.
- tx_data  in  8  byte to transmit; bits above data_bits-1 ignored.
- tx_wr  in  1  push tx_data into TX FIFO.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  TX FIFO not empty or shifter active.
- rx_data  out  8  RX FIFO head (first-word fall-through); bits above data_bits-1 are 0.
- rx_avail  out  1  RX FIFO not empty.
- rx_ack  in  1  pop RX FIFO head.
- rx_level  out  log2(fifo_depth)+1  RX FIFO occupancy.
- err_clr  in  1  clear all sticky error flags.
- rx_frame_err  out  1  sticky: stop bit sampled 0.
- rx_parity_err  out  1  sticky: parity mismatch.
- rx_overrun  out  1  sticky: byte received while RX FIFO full.

Behaviour:

Reset:
- reset_n low asynchronously forces uart_txd=1; all FIFO pointers, levels, flags and rx_data to 0; both FSMs to IDLE.
- Reset mid-frame aborts the frame; FIFO contents are lost.

Tick generator:
- Free-running counter issues a 1-cycle tick every divisor clocks. It runs continuously; TX and RX keep their own 0..15 sub-counters.

TX FIFO:
- tx_wr while not full: push.
- tx_wr while full: write dropped, no error, occupancy unchanged.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE: when FIFO non-empty, pop and load shifter on the next tick boundary.
- Each state lasts 16 ticks. Data goes out LSB first for data_bits bits.
- PARITY is present only if parity != 0. Odd parity: bit makes the total ones count odd; even: total ones even.
- STOP drives 1 for 16*stop_bits ticks.
- A new frame starts immediately after STOP if the FIFO is non-empty; no idle gap.

RX:
- uart_rxd passes through a 2-FF synchroniser before use.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: a falling edge on the synchronised input enters START.
- START: resample at tick 8. If the line is high, treat as a glitch and return to IDLE.
- Subsequent bits are sampled every 16 ticks (mid-bit).
- Only the first stop bit is checked; RX returns to IDLE after the first stop bit's mid-sample, so it tolerates 1 or 2 stop bits from the sender.

End-of-frame outcome (at the stop-bit sample):
- Stop bit = 0: set rx_frame_err and discard the byte.
- Parity mismatch: set rx_parity_err; the byte is still pushed.
- RX FIFO full: set rx_overrun and drop the new byte; existing contents are kept.

RX FIFO:
- rx_ack while rx_avail: pop; the next head appears on rx_data in the following cycle.
- rx_ack while empty: ignored.
- Push and pop in the same cycle: both happen; level unchanged.
- Push and pop in the same cycle when full: pop occurs first, so the push succeeds and no overrun is flagged.

Error flags:
- err_clr clears all flags in the next cycle.
- err_clr in the same cycle as a new error: the set wins.

Test Plan:
1. freq_hz=16000000, baud=1000000 (divisor 1, 16 clk/bit), 8N1. Push 0xA5 → uart_txd shows 0, then 1,0,1,0,0,1,0,1, then 1. Each bit lasts 16 clocks. tx_busy clears 160 clocks after the start bit.
2. Loopback uart_txd→uart_rxd, push 0x00, 0xFF, 0x55 back-to-back → rx_level reaches 3 and rx_data pops 0x00, 0xFF, 0x55 in order. No error flags are set.
3. data_bits=7, parity=2 (even), stop_bits=2: send 0x41 → frame is 0,1000001,0,1,1. Receiver yields 0x41 with rx_parity_err=0. Inject parity bit 1 → rx_parity_err=1 and 0x41 is still pushed.
4. Drive a stop bit of 0 → rx_frame_err=1, rx_level unchanged. Assert err_clr → flag clears next cycle.
5. fifo_depth=4: receive 5 bytes with no rx_ack → rx_level=4, rx_overrun=1, FIFO holds bytes 1..4. Hold tx_wr for 6 cycles → only 4 bytes are accepted and tx_full=1.
6. Glitch: 3-clock low pulse on uart_rxd → no byte and no error. Deassert reset_n mid-TX-frame → uart_txd=1 immediately; after release, tx_busy=0 and rx_avail=0.

Source files
------------

// File: rtl/uart_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_if
// Purpose  : Host-side bundle of uart_fifo: TX/RX FIFO handshakes and flags.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    tx_data;
  logic          tx_wr;
  logic          tx_full;
  logic          tx_busy;
  logic [7:0]    rx_data;
  logic          rx_avail;
  logic          rx_ack;
  logic [LW-1:0] rx_level;
  logic          err_clr;
  logic          rx_frame_err;
  logic          rx_parity_err;
  logic          rx_overrun;

  modport master (
    output tx_data, tx_wr, rx_ack, err_clr,
    input  tx_full, tx_busy, rx_data, rx_avail, rx_level,
           rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_wr, rx_ack, err_clr,
    output tx_full, tx_busy, rx_data, rx_avail, rx_level,
           rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo
// Purpose  : UART with configurable framing, TX/RX FIFOs and sticky RX errors.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo #(
  parameter int FREQ_HZ    = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  input  wire logic  uart_rxd,
  output logic       uart_txd,
  uart_fifo_if.slave bus
);
  localparam int DIV_RAW = (FREQ_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam logic [7:0] DMASK     = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0] DLAST     = 3'(DATA_BITS - 1);
  localparam logic [4:0] STOP_LAST = 5'(16 * STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // ---------------- 16x oversampling tick ----------------
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == TW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    txf_mem [FIFO_DEPTH];
  logic [AW-1:0] txf_wr_q, txf_rd_q;
  logic [LW-1:0] txf_cnt_q;
  logic          txf_full, txf_empty, txf_push, tx_pop;
  logic [7:0]    tx_head;
  logic          tx_par_bit;

  assign txf_full  = (txf_cnt_q == LW'(FIFO_DEPTH));
  assign txf_empty = (txf_cnt_q == '0);
  assign txf_push  = bus.tx_wr && !txf_full;
  assign tx_head   = txf_mem[txf_rd_q];
  assign tx_par_bit = (PARITY == 1) ? ~(^tx_head) : (^tx_head);

  always_ff @(posedge clk) begin
    if (txf_push) txf_mem[txf_wr_q] <= bus.tx_data & DMASK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txf_wr_q  <= '0;
      txf_rd_q  <= '0;
      txf_cnt_q <= '0;
    end else begin
      if (txf_push) txf_wr_q <= txf_wr_q + AW'(1);
      if (tx_pop)   txf_rd_q <= txf_rd_q + AW'(1);
      txf_cnt_q <= txf_cnt_q + LW'(txf_push) - LW'(tx_pop);
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t  tx_state_q;
  logic [4:0] tx_cnt_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_shift_q;
  logic       tx_par_q;
  logic       tx_txd_q;

  // Popping at the end of STOP chains frames with no idle gap.
  assign tx_pop = tick && !txf_empty &&
                  ((tx_state_q == TX_IDLE) ||
                   ((tx_state_q == TX_STOP) && (tx_cnt_q == STOP_LAST)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_txd_q   <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q <= TX_START;
      tx_cnt_q   <= '0;
      tx_shift_q <= tx_head;
      tx_par_q   <= tx_par_bit;
      tx_txd_q   <= 1'b0;
    end else if (tick) begin
      case (tx_state_q)
        TX_IDLE: tx_txd_q <= 1'b1;
        TX_START: begin
          if (tx_cnt_q == 5'd15) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
            tx_txd_q   <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + 5'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == 5'd15) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == DLAST) begin
              if (PARITY != 0) begin
                tx_state_q <= TX_PARITY;
                tx_txd_q   <= tx_par_q;
              end else begin
                tx_state_q <= TX_STOP;
                tx_txd_q   <= 1'b1;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_txd_q   <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 5'd1;
          end
        end
        TX_PARITY: begin
          if (tx_cnt_q == 5'd15) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_STOP;
            tx_txd_q   <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 5'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == STOP_LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
            tx_txd_q   <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 5'd1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_txd    = tx_txd_q;
  assign bus.tx_full = txf_full;
  assign bus.tx_busy = !txf_empty || (tx_state_q != TX_IDLE);

  // ---------------- RX synchroniser and FSM ----------------
  logic       rxd_s1_q, rxd_s2_q, rxd_prev_q;
  rx_state_t  rx_state_q;
  logic [3:0] rx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_shift_q;
  logic       rx_par_q;
  logic       rx_perr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rxd_prev_q && !rxd_s2_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_cnt_q == 4'd7) begin
              rx_cnt_q <= '0;
              if (rxd_s2_q) begin
                rx_state_q <= RX_IDLE;
              end else begin
                rx_state_q <= RX_DATA;
                rx_bit_q   <= '0;
                rx_shift_q <= '0;
                rx_par_q   <= 1'b0;
                rx_perr_q  <= 1'b0;
              end
            end else begin
              rx_cnt_q <= rx_cnt_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_cnt_q == 4'd15) begin
              rx_cnt_q             <= '0;
              rx_shift_q[rx_bit_q] <= rxd_s2_q;
              rx_par_q             <= rx_par_q ^ rxd_s2_q;
              if (rx_bit_q == DLAST)
                rx_state_q <= (PARITY != 0) ? RX_PARITY : RX_STOP;
              else
                rx_bit_q <= rx_bit_q + 3'd1;
            end else begin
              rx_cnt_q <= rx_cnt_q + 4'd1;
            end
          end
        end
        RX_PARITY: begin
          if (tick) begin
            if (rx_cnt_q == 4'd15) begin
              rx_cnt_q   <= '0;
              rx_state_q <= RX_STOP;
              rx_perr_q  <= (PARITY == 1) ? ~(rx_par_q ^ rxd_s2_q)
                                          : (rx_par_q ^ rxd_s2_q);
            end else begin
              rx_cnt_q <= rx_cnt_q + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_cnt_q == 4'd15) begin
              rx_cnt_q   <= '0;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_cnt_q <= rx_cnt_q + 4'd1;
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO and sticky flags ----------------
  logic [7:0]    rxf_mem [FIFO_DEPTH];
  logic [AW-1:0] rxf_wr_q, rxf_rd_q;
  logic [LW-1:0] rxf_cnt_q;
  logic          rxf_full, rxf_empty;
  logic          stop_sample, push_req, rx_push, rx_pop;
  logic          frame_set, perr_set, ovr_set;
  logic          frame_err_q, parity_err_q, overrun_q;

  assign rxf_full    = (rxf_cnt_q == LW'(FIFO_DEPTH));
  assign rxf_empty   = (rxf_cnt_q == '0);
  assign stop_sample = (rx_state_q == RX_STOP) && tick && (rx_cnt_q == 4'd15);
  assign push_req    = stop_sample && rxd_s2_q;
  assign rx_pop      = bus.rx_ack && !rxf_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign rx_push     = push_req && (!rxf_full || rx_pop);
  assign frame_set   = stop_sample && !rxd_s2_q;
  assign perr_set    = push_req && rx_perr_q;
  assign ovr_set     = push_req && rxf_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push) rxf_mem[rxf_wr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxf_wr_q     <= '0;
      rxf_rd_q     <= '0;
      rxf_cnt_q    <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (rx_push) rxf_wr_q <= rxf_wr_q + AW'(1);
      if (rx_pop)  rxf_rd_q <= rxf_rd_q + AW'(1);
      rxf_cnt_q    <= rxf_cnt_q + LW'(rx_push) - LW'(rx_pop);
      frame_err_q  <= frame_set || (frame_err_q  && !bus.err_clr);
      parity_err_q <= perr_set  || (parity_err_q && !bus.err_clr);
      overrun_q    <= ovr_set   || (overrun_q    && !bus.err_clr);
    end
  end

  assign bus.rx_data       = rxf_empty ? 8'h00 : rxf_mem[rxf_rd_q];
  assign bus.rx_avail      = !rxf_empty;
  assign bus.rx_level      = rxf_cnt_q;
  assign bus.rx_frame_err  = frame_err_q;
  assign bus.rx_parity_err = parity_err_q;
  assign bus.rx_overrun    = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo
// Purpose  : Self-checking bench: 8N1 loopback unit (A) and 7E2 unit (B).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic txd_a, txd_b, rxd_a, drv_a, drv_b, loop_a;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_q[$];

  uart_fifo_if #(.FIFO_DEPTH(4)) ifa ();
  uart_fifo_if #(.FIFO_DEPTH(4)) ifb ();

  assign rxd_a = loop_a ? txd_a : drv_a;

  uart_fifo #(.FREQ_HZ(16000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(0),
              .STOP_BITS(1), .FIFO_DEPTH(4))
  dut_a (.clk(clk), .reset_n(reset_n), .uart_rxd(rxd_a), .uart_txd(txd_a), .bus(ifa));

  uart_fifo #(.FREQ_HZ(16000000), .BAUD(1000000), .DATA_BITS(7), .PARITY(2),
              .STOP_BITS(2), .FIFO_DEPTH(4))
  dut_b (.clk(clk), .reset_n(reset_n), .uart_rxd(drv_b), .uart_txd(txd_b), .bus(ifb));

  typedef struct {
    logic [7:0] data;
    bit         flip;
    bit         stopv;
    bit         push;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } rxvec_t;

  rxvec_t tbl[7];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic txd_of(input int d);
    return (d == 0) ? txd_a : txd_b;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? ifa.tx_busy : ifb.tx_busy;
  endfunction

  task automatic push(input int d, input logic [7:0] v);
    @(negedge clk);
    if (d == 0) begin ifa.tx_data = v; ifa.tx_wr = 1'b1; end
    else        begin ifb.tx_data = v; ifb.tx_wr = 1'b1; end
    @(negedge clk);
    ifa.tx_wr = 1'b0;
    ifb.tx_wr = 1'b0;
  endtask

  task automatic pop(input int d);
    @(negedge clk);
    if (d == 0) ifa.rx_ack = 1'b1; else ifb.rx_ack = 1'b1;
    @(negedge clk);
    ifa.rx_ack = 1'b0;
    ifb.rx_ack = 1'b0;
  endtask

  task automatic clear_errs();
    @(negedge clk);
    ifa.err_clr = 1'b1;
    ifb.err_clr = 1'b1;
    @(negedge clk);
    ifa.err_clr = 1'b0;
    ifb.err_clr = 1'b0;
  endtask

  // Builds a frame from the line rules and bit-bangs it at 16 clocks per bit.
  task automatic send_frame(input int d, input logic [7:0] v, input int nb,
                            input int par, input bit flip, input bit stopv, input int ns);
    logic bits[$];
    int   ones = 0;
    logic p;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(v[i]);
      ones += int'(v[i]);
    end
    if (par != 0) begin
      p = (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      bits.push_back(p ^ flip);
    end
    bits.push_back(stopv);
    for (int i = 1; i < ns; i++) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++) begin
      if (d == 0) drv_a = bits[i]; else drv_b = bits[i];
      repeat (16) @(negedge clk);
    end
    if (d == 0) drv_a = 1'b1; else drv_b = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  // Expected line waveform is derived from the frame rules, sampled mid-bit.
  task automatic check_tx(input int d, input logic [7:0] v, input int nb,
                          input int par, input int ns, input string nm);
    logic bits[$];
    int   ones = 0;
    int   k;
    bit   seen = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(v[i]);
      ones += int'(v[i]);
    end
    if (par == 1) bits.push_back(ones % 2 == 0);
    else if (par == 2) bits.push_back(ones % 2 == 1);
    for (int i = 0; i < ns; i++) bits.push_back(1'b1);
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (txd_of(d) == 1'b0) seen = 1'b1;
    end
    chk({nm, "_start"}, int'(seen), 1);
    if (seen) begin
      k = 0;
      while (busy_of(d) && k < 16 * bits.size() + 40) begin
        if (k % 16 == 8 && k / 16 < bits.size())
          chk($sformatf("%s_bit%0d", nm, k / 16), int'(txd_of(d)), int'(bits[k / 16]));
        @(negedge clk);
        k++;
      end
      chk({nm, "_busy_len"}, k, 16 * bits.size());
    end
  endtask

  // Loopback traffic on A against the queue model; pops at random moments.
  task automatic run_loop(input int n_rand, input string nm);
    int sent = 0;
    int cyc  = 0;
    bit done = 1'b0;
    while (!done && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      ifa.tx_wr  = 1'b0;
      ifa.rx_ack = 1'b0;
      if (ifa.rx_avail) begin
        if ($urandom_range(1, 0) == 1) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_extra: got %0h want none", nm, ifa.rx_data);
          end else begin
            chk({nm, "_data"}, int'(ifa.rx_data), int'(exp_q.pop_front()));
          end
          ifa.rx_ack = 1'b1;
        end
      end else if ($urandom_range(7, 0) == 0) begin
        ifa.rx_ack = 1'b1;
      end
      if (sent < n_rand && $urandom_range(3, 0) == 0) begin
        ifa.tx_data = 8'($urandom);
        ifa.tx_wr   = 1'b1;
        if (!ifa.tx_full) begin
          exp_q.push_back(ifa.tx_data);
          sent++;
        end
      end
      done = (sent == n_rand) && (exp_q.size() == 0) && !ifa.tx_busy;
    end
    ifa.tx_wr  = 1'b0;
    ifa.rx_ack = 1'b0;
    chk({nm, "_drained"}, exp_q.size(), 0);
    repeat (4) @(negedge clk);
    chk({nm, "_rx_empty"}, int'(ifa.rx_level), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h41, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    tbl[1] = '{8'h41, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'h7F, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
    tbl[4] = '{8'hC3, 1'b0, 1'b1, 1'b1, 8'h43, 1'b0, 1'b0};
    tbl[5] = '{8'h2A, 1'b1, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0};
    tbl[6] = '{8'h15, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

    reset_n = 1'b0;
    drv_a = 1'b1; drv_b = 1'b1; loop_a = 1'b0;
    ifa.tx_data = 8'h00; ifa.tx_wr = 1'b0; ifa.rx_ack = 1'b0; ifa.err_clr = 1'b0;
    ifb.tx_data = 8'h00; ifb.tx_wr = 1'b0; ifb.rx_ack = 1'b0; ifb.err_clr = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_txd_a", int'(txd_a), 1);
    chk("rst_txd_b", int'(txd_b), 1);
    chk("rst_busy", int'(ifa.tx_busy), 0);
    chk("rst_full", int'(ifa.tx_full), 0);
    chk("rst_avail", int'(ifa.rx_avail), 0);
    chk("rst_level", int'(ifa.rx_level), 0);
    chk("rst_rx_data", int'(ifa.rx_data), 0);
    chk("rst_flags", int'({ifa.rx_frame_err, ifa.rx_parity_err, ifa.rx_overrun}), 0);

    // 8N1 transmit waveform and busy length
    push(0, 8'hA5);
    check_tx(0, 8'hA5, 8, 0, 1, "tx_a5");

    // 7E2 transmit; bit 7 of the written byte must not reach the line
    push(1, 8'h41);
    check_tx(1, 8'h41, 7, 2, 2, "tx_b41");
    push(1, 8'hC1);
    check_tx(1, 8'h41, 7, 2, 2, "tx_bc1");

    // 7E2 receive vectors
    for (int i = 0; i < 7; i++) begin
      clear_errs();
      send_frame(1, tbl[i].data, 7, 2, tbl[i].flip, tbl[i].stopv, 2);
      chk($sformatf("tbl%0d_level", i), int'(ifb.rx_level), int'(tbl[i].push));
      if (tbl[i].push) chk($sformatf("tbl%0d_data", i), int'(ifb.rx_data), int'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_perr", i), int'(ifb.rx_parity_err), int'(tbl[i].exp_perr));
      chk($sformatf("tbl%0d_ferr", i), int'(ifb.rx_frame_err), int'(tbl[i].exp_ferr));
      if (tbl[i].push) pop(1);
    end

    // Loopback: three back-to-back bytes accumulate, then pop in order
    loop_a = 1'b1;
    @(negedge clk); ifa.tx_data = 8'h00; ifa.tx_wr = 1'b1;
    @(negedge clk); ifa.tx_data = 8'hFF;
    @(negedge clk); ifa.tx_data = 8'h55;
    @(negedge clk); ifa.tx_wr = 1'b0;
    for (int t = 0; t < 800 && ifa.rx_level != 3; t++) @(negedge clk);
    chk("lb_level3", int'(ifa.rx_level), 3);
    chk("lb_pop0", int'(ifa.rx_data), 8'h00); pop(0);
    chk("lb_pop1", int'(ifa.rx_data), 8'hFF); pop(0);
    chk("lb_pop2", int'(ifa.rx_data), 8'h55); pop(0);
    chk("lb_level0", int'(ifa.rx_level), 0);
    chk("lb_flags", int'({ifa.rx_frame_err, ifa.rx_parity_err, ifa.rx_overrun}), 0);

    // TX FIFO full: shifter busy, 6 writes, only 4 land
    push(0, 8'h11);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ifa.tx_data = 8'h20 + 8'(i);
      ifa.tx_wr   = 1'b1;
    end
    @(negedge clk);
    ifa.tx_wr = 1'b0;
    chk("txfull", int'(ifa.tx_full), 1);
    exp_q = '{8'h11, 8'h20, 8'h21, 8'h22, 8'h23};
    run_loop(0, "txfull_drain");

    // Randomised loopback traffic
    run_loop(24, "rand");
    chk("rand_flags", int'({ifa.rx_frame_err, ifa.rx_parity_err, ifa.rx_overrun}), 0);
    loop_a = 1'b0;

    // Frame error: byte dropped, flag sticky, err_clr clears it next cycle
    send_frame(0, 8'h3C, 8, 0, 1'b0, 1'b0, 1);
    chk("ferr_flag", int'(ifa.rx_frame_err), 1);
    chk("ferr_level", int'(ifa.rx_level), 0);
    @(negedge clk);
    ifa.err_clr = 1'b1;
    @(negedge clk);
    chk("ferr_clr", int'(ifa.rx_frame_err), 0);
    ifa.err_clr = 1'b0;

    // RX overrun: fifth byte dropped, first four kept
    for (int i = 0; i < 5; i++) send_frame(0, 8'h31 + 8'(i), 8, 0, 1'b0, 1'b1, 1);
    chk("ovr_level", int'(ifa.rx_level), 4);
    chk("ovr_flag", int'(ifa.rx_overrun), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovr_pop%0d", i), int'(ifa.rx_data), 8'h31 + i);
      pop(0);
    end
    chk("ovr_empty", int'(ifa.rx_avail), 0);
    clear_errs();

    // Glitch shorter than half a bit
    @(negedge clk);
    drv_a = 1'b0;
    repeat (3) @(negedge clk);
    drv_a = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_level", int'(ifa.rx_level), 0);
    chk("glitch_flags", int'({ifa.rx_frame_err, ifa.rx_parity_err, ifa.rx_overrun}), 0);
    send_frame(0, 8'h5A, 8, 0, 1'b0, 1'b1, 1);
    chk("post_glitch_data", int'(ifa.rx_data), 8'h5A);
    chk("post_glitch_avail", int'(ifa.rx_avail), 1);

    // Reset mid-frame: line returns high at once, state and FIFOs cleared
    push(0, 8'h00);
    repeat (30) @(negedge clk);
    chk("midtx_low", int'(txd_a), 0);
    reset_n = 1'b0;
    #1;
    chk("midtx_rst_txd", int'(txd_a), 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(ifa.tx_busy), 0);
    chk("post_rst_avail", int'(ifa.rx_avail), 0);
    chk("post_rst_txd", int'(txd_a), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
